// File: rtl/vec_addsub_fifo.sv
// vec_addsub_fifo: lane-wise vector add/subtract with optional saturation,
// fed from an upstream FWFT FIFO and buffered into an integrated FWFT
// output FIFO so a result can be produced every cycle.
module vec_addsub_fifo #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DEPTH    = 16,
  parameter bit          SAT      = 1'b0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS*WIDTH-1:0]      x,
  input  logic [CHANNELS*WIDTH-1:0]      y,
  input  logic                           op,
  input  logic                           in_empty,
  output logic                           in_rd_en,
  output logic [CHANNELS*WIDTH-1:0]      out,
  output logic                           out_empty,
  input  logic                           out_rd_en,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           ovf,
  input  logic                           ovf_clear
);

  localparam int unsigned VW = CHANNELS * WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [VW-1:0]       res_c;
  logic [CHANNELS-1:0] lane_ovf_c;
  logic                wr_en_c;
  logic                rd_en_c;

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [VW-1:0]       mem [DEPTH];

  // Per-lane arithmetic at WIDTH+1 bits, then wrap or clamp back to WIDTH
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic signed [WIDTH:0] xe;
    logic signed [WIDTH:0] ye;
    logic signed [WIDTH:0] se;
    logic                  lane_ovf;
    logic [WIDTH-1:0]      lane_res;

    // Sign-extend one bit so the sum/difference is always exact
    always_comb begin
      xe       = {x[i*WIDTH+WIDTH-1], x[i*WIDTH +: WIDTH]};
      ye       = {y[i*WIDTH+WIDTH-1], y[i*WIDTH +: WIDTH]};
      se       = op ? (xe + ye) : (xe - ye);
      lane_ovf = se[WIDTH] ^ se[WIDTH-1];
      lane_res = se[WIDTH-1:0];
      if (SAT && lane_ovf) begin
        lane_res = se[WIDTH] ? MIN_NEG : MAX_POS;
      end
    end

    assign res_c[i*WIDTH +: WIDTH] = lane_res;
    assign lane_ovf_c[i]           = lane_ovf;
  end

  // Handshakes: accept while not full, pop only when something is buffered
  always_comb begin
    out_empty = (count == '0);
    in_rd_en  = !in_empty && (count < CW'(DEPTH));
    wr_en_c   = in_rd_en;
    rd_en_c   = out_rd_en && !out_empty;
  end

  // FWFT head: zero whenever the buffer is empty
  always_comb begin
    out = '0;
    if (!out_empty) begin
      out = mem[rd_ptr];
    end
  end

  // Result storage; contents are intentionally not reset
  always_ff @(posedge clock) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= res_c;
    end
  end

  // Pointers and occupancy; reset flushes everything buffered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en_c, rd_en_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow beats a same-cycle clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (wr_en_c && (|lane_ovf_c)) begin
      ovf <= 1'b1;
    end else if (ovf_clear) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vec_addsub_fifo.sv
// Bench for vec_addsub_fifo: a wrapping and a saturating instance share the
// same stimulus and are checked every cycle against a queue-based model.
module tb_vec_addsub_fifo;

  localparam int unsigned W  = 32;
  localparam int unsigned C  = 3;
  localparam int unsigned D  = 4;
  localparam int unsigned VW = W * C;
  localparam int unsigned CW = $clog2(D) + 1;

  typedef struct packed {
    logic [VW-1:0] x;
    logic [VW-1:0] y;
    logic          op;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [VW-1:0] x, y;
  logic          op, in_empty, out_rd_en, ovf_clear;
  logic          in_rd_en_w, in_rd_en_s, out_empty_w, out_empty_s, ovf_w, ovf_s;
  logic [VW-1:0] out_w, out_s;
  logic [CW-1:0] count_w, count_s;

  vec_t          up_q[$];
  logic [VW-1:0] exp_w[$];
  logic [VW-1:0] exp_s[$];
  bit            exp_ovf = 1'b0;
  bit            hold;
  bit            run_chk = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clock = ~clock;

  vec_addsub_fifo #(.WIDTH(W), .CHANNELS(C), .DEPTH(D), .SAT(1'b0)) u_wrap (
    .clock(clock), .reset(reset), .x(x), .y(y), .op(op), .in_empty(in_empty),
    .in_rd_en(in_rd_en_w), .out(out_w), .out_empty(out_empty_w),
    .out_rd_en(out_rd_en), .count(count_w), .ovf(ovf_w), .ovf_clear(ovf_clear));

  vec_addsub_fifo #(.WIDTH(W), .CHANNELS(C), .DEPTH(D), .SAT(1'b1)) u_sat (
    .clock(clock), .reset(reset), .x(x), .y(y), .op(op), .in_empty(in_empty),
    .in_rd_en(in_rd_en_s), .out(out_s), .out_empty(out_empty_s),
    .out_rd_en(out_rd_en), .count(count_s), .ovf(ovf_s), .ovf_clear(ovf_clear));

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact integer result, then wrap or clamp; bit VW = overflow
  function automatic logic [VW:0] calc(input vec_t v, input bit sat);
    logic [VW-1:0] r;
    bit            o;
    longint        a, b, s;
    r = '0;
    o = 1'b0;
    for (int i = 0; i < int'(C); i++) begin
      a = longint'($signed(v.x[i*W +: W]));
      b = longint'($signed(v.y[i*W +: W]));
      s = v.op ? (a + b) : (a - b);
      if (s > 64'sd2147483647) begin
        o = 1'b1;
        r[i*W +: W] = sat ? 32'h7FFFFFFF : s[31:0];
      end else if (s < -64'sd2147483648) begin
        o = 1'b1;
        r[i*W +: W] = sat ? 32'h80000000 : s[31:0];
      end else begin
        r[i*W +: W] = s[31:0];
      end
    end
    return {o, r};
  endfunction

  function automatic logic [31:0] rl();
    case ($urandom_range(0, 6))
      0:       return 32'h7FFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h00000000;
      4:       return 32'h00000001;
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic vec_t rvec();
    vec_t v;
    v.x  = {rl(), rl(), rl()};
    v.y  = {rl(), rl(), rl()};
    v.op = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Lane 0 is the least significant slice
  function automatic vec_t mk(input logic [31:0] x0, x1, x2, y0, y1, y2, input logic o);
    vec_t v;
    v.x  = {x2, x1, x0};
    v.y  = {y2, y1, y0};
    v.op = o;
    return v;
  endfunction

  // Compare every DUT output against the model, away from the active edge
  logic [VW-1:0] hw, hs;
  bit            e_acc;
  always @(negedge clock) begin
    if (!reset && run_chk) begin
      hw    = (exp_w.size() > 0) ? exp_w[0] : '0;
      hs    = (exp_s.size() > 0) ? exp_s[0] : '0;
      e_acc = !in_empty && (exp_w.size() < int'(D));
      chk("out_wrap", out_w, hw);
      chk("out_sat", out_s, hs);
      chk("count_wrap", VW'(count_w), VW'(exp_w.size()));
      chk("count_sat", VW'(count_s), VW'(exp_s.size()));
      chk("empty_wrap", VW'(out_empty_w), VW'(exp_w.size() == 0));
      chk("empty_sat", VW'(out_empty_s), VW'(exp_s.size() == 0));
      chk("in_rd_en_wrap", VW'(in_rd_en_w), VW'(e_acc));
      chk("in_rd_en_sat", VW'(in_rd_en_s), VW'(e_acc));
      chk("ovf_wrap", VW'(ovf_w), VW'(exp_ovf));
      chk("ovf_sat", VW'(ovf_s), VW'(exp_ovf));
    end
  end

  // Advance the model at the edge using the inputs that were presented
  bit            m_acc, m_pop;
  logic [VW:0]   rw, rs;
  always @(posedge clock) begin
    if (!reset) begin
      m_acc = !in_empty && (exp_w.size() < int'(D)) && (up_q.size() > 0);
      m_pop = out_rd_en && (exp_w.size() > 0);
      if (m_pop) begin
        void'(exp_w.pop_front());
        void'(exp_s.pop_front());
      end
      if (m_acc) begin
        rw = calc(up_q[0], 1'b0);
        rs = calc(up_q[0], 1'b1);
        exp_w.push_back(rw[VW-1:0]);
        exp_s.push_back(rs[VW-1:0]);
        void'(up_q.pop_front());
      end
      if (m_acc && rw[VW]) exp_ovf = 1'b1;
      else if (ovf_clear)  exp_ovf = 1'b0;
    end
  end

  task automatic drive();
    in_empty = hold || (up_q.size() == 0);
    if (up_q.size() > 0) begin
      x  = up_q[0].x;
      y  = up_q[0].y;
      op = up_q[0].op;
    end else begin
      x  = {32'($urandom), 32'($urandom), 32'($urandom)};
      y  = {32'($urandom), 32'($urandom), 32'($urandom)};
      op = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic step(input bit h, input bit rd, input bit clr);
    hold      = h;
    out_rd_en = rd;
    ovf_clear = clr;
    drive();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && exp_w.size() > 0; k++) step(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; hold = 1'b1; out_rd_en = 1'b0; ovf_clear = 1'b0;
    drive();
    #1;
    chk("rst_count", VW'(count_w), VW'(0));
    chk("rst_empty", VW'(out_empty_s), VW'(1));
    chk("rst_out", out_w, '0);
    chk("rst_ovf", VW'(ovf_s), VW'(0));
    chk("rst_in_rd_en", VW'(in_rd_en_w), VW'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    run_chk = 1'b1;

    // Plain subtract
    up_q.push_back(mk(32'd5, -32'sd3, 32'd100, 32'd2, 32'd4, -32'sd100, 1'b0));
    step(1'b0, 1'b0, 1'b0);
    chk("sub_out", out_w, {32'd200, 32'hFFFFFFF9, 32'd3});
    chk("sub_out_sat", out_s, {32'd200, 32'hFFFFFFF9, 32'd3});
    chk("sub_ovf", VW'(ovf_w), VW'(0));
    step(1'b1, 1'b1, 1'b0);

    // Positive overflow on add, sticky flag, clear vs set priority
    up_q.push_back(mk(32'h7FFFFFFF, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 1'b1));
    step(1'b0, 1'b1, 1'b0);
    chk("add_ovf_wrap", out_w, {32'd2, 32'd2, 32'h80000000});
    chk("add_ovf_sat", out_s, {32'd2, 32'd2, 32'h7FFFFFFF});
    chk("ovf_set", VW'(ovf_w), VW'(1));
    repeat (3) step(1'b1, 1'b0, 1'b0);
    chk("ovf_sticky", VW'(ovf_s), VW'(1));
    up_q.push_back(mk(32'h7FFFFFFF, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 1'b1));
    step(1'b0, 1'b0, 1'b1);
    chk("ovf_set_beats_clear", VW'(ovf_w), VW'(1));
    step(1'b1, 1'b0, 1'b1);
    chk("ovf_cleared", VW'(ovf_w), VW'(0));
    drain();

    // Negative and positive overflow on subtract
    up_q.push_back(mk(32'h80000000, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 1'b0));
    up_q.push_back(mk(32'h7FFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0));
    step(1'b0, 1'b0, 1'b0);
    chk("neg_clamp_sat", out_s, {32'd0, 32'd0, 32'h80000000});
    chk("neg_wrap", out_w, {32'd0, 32'd0, 32'h7FFFFFFF});
    step(1'b0, 1'b0, 1'b0);
    chk("two_count", VW'(count_w), VW'(2));
    step(1'b1, 1'b1, 1'b0);
    chk("pos_clamp_sat", out_s, {32'd0, 32'd0, 32'h7FFFFFFF});
    chk("pos_wrap", out_w, {32'd0, 32'd0, 32'h80000000});
    drain();
    step(1'b1, 1'b0, 1'b1);

    // Fill to full with six waiting upstream, then one pop reopens input
    repeat (6) up_q.push_back(rvec());
    repeat (6) step(1'b0, 1'b0, 1'b0);
    chk("full_count", VW'(count_w), VW'(4));
    chk("full_in_rd_en", VW'(in_rd_en_w), VW'(0));
    step(1'b0, 1'b1, 1'b0);
    chk("after_pop_count", VW'(count_s), VW'(3));
    chk("after_pop_in_rd_en", VW'(in_rd_en_s), VW'(1));
    repeat (4) up_q.push_back(rvec());
    for (int k = 0; k < 30 && (up_q.size() > 0 || exp_w.size() > 0); k++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    drain();

    // Streaming: push and pop every cycle at occupancy one
    repeat (21) up_q.push_back(rvec());
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("stream_count", VW'(count_w), VW'(1));
      chk("stream_in_rd_en", VW'(in_rd_en_w), VW'(1));
    end
    drain();

    // Asynchronous reset with three buffered results and ovf set
    up_q.push_back(mk(32'h7FFFFFFF, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 1'b1));
    repeat (2) up_q.push_back(rvec());
    up_q.push_back(rvec());
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", VW'(count_w), VW'(3));
    hold = 1'b1;
    drive();
    #2 reset = 1'b1;
    #1;
    chk("arst_empty", VW'(out_empty_w), VW'(1));
    chk("arst_out", out_w, '0);
    chk("arst_count", VW'(count_s), VW'(0));
    chk("arst_ovf", VW'(ovf_w), VW'(0));
    exp_w.delete();
    exp_s.delete();
    exp_ovf = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    chk("pop_empty_count", VW'(count_w), VW'(0));
    chk("pop_empty_flag", VW'(out_empty_w), VW'(1));

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) != 0 && up_q.size() < 8) up_q.push_back(rvec());
      step(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 9) == 0));
    end
    for (int k = 0; k < 20 && (up_q.size() > 0 || exp_w.size() > 0); k++)
      step(1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
